// File: rtl/rca_share_arb.sv
// Two-requester round-robin arbiter sharing one ripple-carry adder.
// One request in flight at a time: IDLE -> CALC -> RESP -> IDLE.

module rca_Nbits #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);
    logic [N:0] w_c;

    assign w_c[0] = Cin;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign S[gi]      = A[gi] ^ B[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
    end

    assign Cout = w_c[N];
endmodule

module rca_share_arb #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_prio;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_id;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_sum;
    logic         r_rsp_cout;

    logic         w_gnt_valid;
    logic         w_gnt_id;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [N-1:0] w_sum;
    logic         w_cout;

    // Grant decision; gated by rst_n so no ready leaks out while in reset.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (rst_n && (r_state == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = r_prio;
            end else if (req0_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b0;
            end else if (req1_valid) begin
                w_gnt_valid = 1'b1;
                w_gnt_id    = 1'b1;
            end else begin
                w_gnt_valid = 1'b0;
                w_gnt_id    = 1'b0;
            end
        end else begin
            w_gnt_valid = 1'b0;
            w_gnt_id    = 1'b0;
        end
    end

    // Operand selection for the granted requester.
    always_comb begin
        w_sel_a = {N{1'b0}};
        w_sel_b = {N{1'b0}};
        if (w_gnt_id) begin
            w_sel_a = req1_a;
            w_sel_b = req1_b;
        end else begin
            w_sel_a = req0_a;
            w_sel_b = req0_b;
        end
    end

    assign req0_ready = w_gnt_valid & ~w_gnt_id;
    assign req1_ready = w_gnt_valid &  w_gnt_id;

    rca_Nbits #(.N(N)) u_rca (
        .A    (r_a),
        .B    (r_b),
        .Cin  (1'b0),
        .S    (w_sum),
        .Cout (w_cout)
    );

    // Arbiter FSM with operand, ID and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prio      <= 1'b0;
            r_a         <= {N{1'b0}};
            r_b         <= {N{1'b0}};
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= {N{1'b0}};
            r_rsp_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_gnt_id;
                        r_prio  <= ~w_gnt_id;
                        r_state <= ST_CALC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rsp_sum   <= w_sum;
                    r_rsp_cout  <= w_cout;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
endmodule

// File: tb/tb_rca_share_arb.sv
// Scoreboard bench for rca_share_arb: directed cases plus randomized traffic
// checked against a transaction-level arbitration/addition model.

module tb_rca_share_arb;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [N-1:0] rsp_sum;

    always #5 clk = ~clk;

    rca_share_arb #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    typedef struct {
        logic         id;
        logic [N-1:0] sum;
        logic         cout;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_rsp   = 0;
    int           cyc     = 0;
    logic         m_prio  = 1'b0;
    logic         m_busy  = 1'b0;
    logic         prev_rv = 1'b0, prev_xfer = 1'b0;
    logic         prev_id, prev_cout;
    logic [N-1:0] prev_sum;
    logic         last_id, last_cout;
    logic [N-1:0] last_sum;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge what the next rising edge will transfer.
    always @(negedge clk) begin
        logic    exp_id;
        int      sum9;
        exp_t    e;
        if (!rst_n) begin
            chk({req0_ready, req1_ready} == 2'b00, "reset_ready", {req0_ready, req1_ready}, 0);
            chk({rsp_valid, rsp_id, rsp_cout, rsp_sum} == '0, "reset_rsp",
                {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 0);
            sb_q.delete();
            m_prio = 1'b0; m_busy = 1'b0; prev_rv = 1'b0; prev_xfer = 1'b0;
        end else begin
            if (m_busy) begin
                chk({req0_ready, req1_ready} == 2'b00, "ready_while_busy", {req0_ready, req1_ready}, 0);
            end else if (req0_valid || req1_valid) begin
                exp_id = (req0_valid && req1_valid) ? m_prio : req1_valid;
                chk({req1_ready, req0_ready} == (exp_id ? 2'b10 : 2'b01), "grant",
                    {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
            end else begin
                chk({req0_ready, req1_ready} == 2'b00, "ready_no_valid", {req0_ready, req1_ready}, 0);
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                e.id   = req1_valid && req1_ready;
                sum9   = e.id ? int'(req1_a) + int'(req1_b) : int'(req0_a) + int'(req0_b);
                e.sum  = sum9[N-1:0];
                e.cout = (sum9 >= 256);
                e.cyc  = cyc;
                sb_q.push_back(e);
                m_prio = ~e.id;
                m_busy = 1'b1;
            end
            if (prev_xfer)
                chk(!rsp_valid, "rsp_drop", rsp_valid, 0);
            if (rsp_valid && !prev_rv) begin
                if (sb_q.size() == 0)
                    chk(1'b0, "spurious_rsp", rsp_valid, 0);
                else
                    chk(cyc == sb_q[0].cyc + 2, "latency", cyc - sb_q[0].cyc, 2);
            end
            if (rsp_valid && prev_rv && !prev_xfer)
                chk({rsp_id, rsp_cout, rsp_sum} == {prev_id, prev_cout, prev_sum}, "rsp_stable",
                    {rsp_id, rsp_cout, rsp_sum}, {prev_id, prev_cout, prev_sum});
            if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(rsp_id == e.id, "rsp_id", rsp_id, e.id);
                chk(rsp_sum == e.sum, "rsp_sum", rsp_sum, e.sum);
                chk(rsp_cout == e.cout, "rsp_cout", rsp_cout, e.cout);
                last_id = rsp_id; last_sum = rsp_sum; last_cout = rsp_cout;
                m_busy = 1'b0;
                n_rsp++;
            end
            prev_xfer = rsp_valid && rsp_ready;
            prev_rv   = rsp_valid;
            prev_id   = rsp_id;
            prev_sum  = rsp_sum;
            prev_cout = rsp_cout;
        end
        cyc++;
    end

    task automatic set_req(input int who, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    // Wait for the accept of one requester, then drop its valid.
    task automatic wait_acc(input int who);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = (who == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
        end
        chk(got, "accept_timeout", who, who);
        @(posedge clk); #1;
        if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 30 && n_rsp < target; i++) @(negedge clk);
        chk(n_rsp >= target, "rsp_timeout", n_rsp, target);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a0, a1;
        int target;
        rst_n = 1'b0; rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h11, 8'h22);
        set_req(1, 1'b1, 8'h33, 8'h44);
        idle(3);
        rst_n = 1'b1;
        wait_acc(0);
        wait_acc(1);
        idle(4);

        // Single request and carry-out cases with fixed expected values.
        target = n_rsp + 1;
        set_req(0, 1'b1, 8'h35, 8'h1A); wait_acc(0); wait_rsp(target);
        chk({last_id, last_cout, last_sum} == {1'b0, 1'b0, 8'h4F}, "dir_35_1A",
            {last_id, last_cout, last_sum}, {1'b0, 1'b0, 8'h4F});
        target = n_rsp + 1;
        set_req(1, 1'b1, 8'hF0, 8'h20); wait_acc(1); wait_rsp(target);
        chk({last_id, last_cout, last_sum} == {1'b1, 1'b1, 8'h10}, "dir_F0_20",
            {last_id, last_cout, last_sum}, {1'b1, 1'b1, 8'h10});
        target = n_rsp + 1;
        set_req(1, 1'b1, 8'h80, 8'h80); wait_acc(1); wait_rsp(target);
        chk({last_id, last_cout, last_sum} == {1'b1, 1'b1, 8'h00}, "dir_80_80",
            {last_id, last_cout, last_sum}, {1'b1, 1'b1, 8'h00});
        idle(2);

        // Contention: both continuously valid, fresh operands after each accept.
        set_req(0, 1'b1, N'($urandom), N'($urandom));
        set_req(1, 1'b1, N'($urandom), N'($urandom));
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready; a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) set_req(0, 1'b1, N'($urandom), N'($urandom));
            if (a1) set_req(1, 1'b1, N'($urandom), N'($urandom));
        end

        // Backpressure: hold the response for 5 cycles with both valids high.
        rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk(rsp_valid, "bp_rsp_seen", rsp_valid, 1);
        idle(5);
        rsp_ready = 1'b1;
        idle(6);
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        idle(4);

        // Reset during CALC after a req1 accept.
        target = n_rsp + 1;
        set_req(0, 1'b1, 8'h01, 8'h02); wait_acc(0); wait_rsp(target);
        set_req(0, 1'b1, 8'h05, 8'h06);
        set_req(1, 1'b1, 8'h07, 8'h08);
        wait_acc(1);
        #2 rst_n = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1, 1'b1, 8'h09, 8'h0A);
        wait_acc(0);
        wait_acc(1);
        idle(4);

        // Randomized traffic with random backpressure and occasional valid drops.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready; a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(3) != 0);
            if (!req0_valid || a0 || $urandom_range(15) == 0)
                set_req(0, 1'($urandom), N'($urandom), N'($urandom));
            if (!req1_valid || a1 || $urandom_range(15) == 0)
                set_req(1, 1'($urandom), N'($urandom), N'($urandom));
        end

        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        rsp_ready = 1'b1;
        idle(8);
        chk(sb_q.size() == 0, "drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_share_arb.md
# rca_share_arb

Two-port round-robin arbiter that shares a single `rca_Nbits` ripple-carry adder between two independent requesters. It accepts one add request at a time over a valid/ready handshake, latches the operands, and registers the adder result. It then returns the sum, carry-out and requester ID on a common response channel. It sits between the lab's operand sources and the adder datapath, so one adder instance serves both clients.

## Interface
- `N`, 8, operand and sum width in bits; passed unchanged to the internal `rca_Nbits #(.N(N))`.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req0_valid`  input  1  requester 0 has an operand pair.
- `req0_a`, `req0_b`  input  N each  requester 0 operands.
- `req0_ready`  output  1  requester 0 transfer accepted this cycle.
- `req1_valid`  input  1  requester 1 has an operand pair.
- `req1_a`, `req1_b`  input  N each  requester 1 operands.
- `req1_ready`  output  1  requester 1 transfer accepted this cycle.
- `rsp_valid`  output  1  response holds a result.
- `rsp_ready`  input  1  consumer takes the response.
- `rsp_id`  output  1  requester that owns the response (0 or 1).
- `rsp_sum`  output  N  (A + B) mod 2^N.
- `rsp_cout`  output  1  unsigned carry out of bit N-1.

## Operation
- **FSM states**
  - IDLE: waiting for a request.
  - CALC: adder evaluating the latched operands.
  - RESP: holding the response until the consumer takes it.
- **IDLE, grant rule**
  - If exactly one `reqX_valid` is high, grant X.
  - If both are high, grant the requester selected by the priority pointer `prio`.
- **IDLE, on grant**
  - Drive `reqX_ready`=1 for the granted requester only, in the same cycle. It is combinational from state, valid and `prio`.
  - At the clock edge, latch `reqX_a`/`reqX_b` into operand registers, latch X into the ID register, set `prio` to the other requester, and go to CALC.
- **IDLE, no valid:** both readies stay 0 and the FSM stays in IDLE.
- **CALC**
  - The `rca_Nbits` inputs are driven only from the operand registers.
  - At the edge, register `S` into `rsp_sum`, `Cout` into `rsp_cout`, and the ID register into `rsp_id`. Set `rsp_valid`=1 and go to RESP.
  - Both readies are 0.
- **RESP**
  - `rsp_valid`=1; `rsp_id`, `rsp_sum` and `rsp_cout` are held stable.
  - When `rsp_ready`=1 at an edge, clear `rsp_valid` and go to IDLE.
  - Both readies are 0.
- **Arithmetic:** unsigned modulo 2^N. Signed callers interpret `rsp_sum` as two's complement; overflow detection is not provided.
- **Requester rules**
  - Requesters must hold valid and operands stable until ready.
  - Valid must not depend combinationally on ready.
  - A requester's valid may drop without being served; no state is kept for it.
- **Fairness:** the pointer only moves on a grant. Two continuously valid requesters alternate 0,1,0,1,...
- **Reset (async, any state)**
  - FSM → IDLE; `prio` = 0 (req0 favoured); `rsp_valid`, `rsp_id`, `rsp_sum` and `rsp_cout` = 0; operand and ID registers = 0.
  - An in-flight operation is discarded and no response is produced.
  - While `rst_n`=0, both readies = 0.

## Timing
- **Handshakes:** an accept is `reqX_valid & reqX_ready` at edge T. A response transfer is `rsp_valid & rsp_ready` at an edge.
- **Latency:** CALC occupies T..T+1 and `rsp_valid` rises after edge T+1. The result is visible on the cycle after CALC: 2 edges from accept.
- **Throughput:** one accept per 3 cycles when `rsp_ready` is tied high. There is no overlap, because the next accept is only possible in IDLE after the response has been taken.
- **Backpressure:** with `rsp_ready`=0, RESP persists indefinitely, outputs are frozen and no new request is accepted.
- **Simultaneous valid and release:** a requester whose valid is asserted in the same cycle the response is taken is granted in the following IDLE cycle, not earlier.

## Test plan
- **Reset:** hold `rst_n`=0 with both valids high → `req0_ready`=`req1_ready`=0 and `rsp_valid`=`rsp_id`=`rsp_sum`=`rsp_cout`=0. After release, the first grant goes to req0.
- **Single request, req0:** `req0_a`=8'h35, `req0_b`=8'h1A, `rsp_ready`=1 → `req0_ready` high one cycle. Two edges later: `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=8'h4F, `rsp_cout`=0 for exactly one cycle.
- **Carry out, req1:** `req1_a`=8'hF0, `req1_b`=8'h20 → `rsp_id`=1, `rsp_sum`=8'h10, `rsp_cout`=1. Repeat with 8'h80+8'h80 → `rsp_sum`=8'h00, `rsp_cout`=1.
- **Contention:** both valid continuously with distinct operands and `rsp_ready`=1 → grant order 0,1,0,1. Each `rsp_id` matches the requester and its sum, checked against `$random` operands plus a reference model.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles during RESP with both valids high → outputs stable and no ready asserted. Release → one transfer, then the next grant goes to the non-previous requester.
- **Reset mid-op:** pulse `rst_n` low during CALC after accepting req1 → no `rsp_valid`. The next both-valid cycle grants req0.
